// File: rtl/iprf_busy_table.sv
// Integer PRF busy table: one busy bit per physical register plus a live count.
// Optional macro IPRF_BUSY_BYPASS_EN adds same-cycle writeback bypass on reads.
package iprf_pkg;
  localparam int IPRF_NUM_WRITES_DEF = 3;
  localparam int IPRF_PDST_W = 6;

  typedef struct packed {
    logic [IPRF_PDST_W-1:0] pdst;
    logic [63:0]            data;
  } t_prf_wr_pkt;
endpackage

module iprf_busy_table
  import iprf_pkg::*;
#(
  parameter int IPRF_NUM_ENTS   = 64,
  parameter int IPRF_NUM_WRITES = IPRF_NUM_WRITES_DEF,
  localparam int IDX_W = $clog2(IPRF_NUM_ENTS),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       alloc_en,
  input  logic [IDX_W-1:0]           alloc_pdst,
  input  logic [IPRF_NUM_WRITES-1:0] iprf_wr_en_ro0,
  input  t_prf_wr_pkt                iprf_wr_pkt_ro0 [IPRF_NUM_WRITES],
  input  logic                       flush,
  input  logic [IDX_W-1:0]           rd_psrc1,
  input  logic [IDX_W-1:0]           rd_psrc2,
  output logic                       rd_psrc1_pend,
  output logic                       rd_psrc2_pend,
  output logic [CNT_W-1:0]           pend_count
);

  logic [IPRF_NUM_ENTS-1:0] busy;
  logic [IPRF_NUM_ENTS-1:0] busy_nxt;
  logic [IPRF_NUM_ENTS-1:0] set_hit;
  logic [IPRF_NUM_ENTS-1:0] clr_hit;
  logic [IPRF_NUM_ENTS-1:0] clr_eff;
  logic [CNT_W-1:0]         inc;
  logic [CNT_W-1:0]         dec;
  logic [CNT_W-1:0]         cnt_nxt;
  logic                     wb_hit1;
  logic                     wb_hit2;

  logic [IPRF_NUM_WRITES*64-1:0] unused_data;

  always_comb begin
    unused_data = '0;
    for (int w = 0; w < IPRF_NUM_WRITES; w++)
      unused_data[w*64 +: 64] = iprf_wr_pkt_ro0[w].data;
  end

  // Register 0 is hardwired ready, so its set is suppressed here.
  always_comb begin
    set_hit = '0;
    clr_hit = '0;
    for (int i = 1; i < IPRF_NUM_ENTS; i++) begin
      set_hit[i] = alloc_en && (int'(alloc_pdst) == i);
      for (int w = 0; w < IPRF_NUM_WRITES; w++)
        if (iprf_wr_en_ro0[w] && (int'(iprf_wr_pkt_ro0[w].pdst) == i))
          clr_hit[i] = 1'b1;
    end
  end

  always_comb begin
    clr_eff = busy & clr_hit & ~set_hit;
    inc     = '0;
    dec     = '0;
    for (int i = 0; i < IPRF_NUM_ENTS; i++) begin
      inc = inc + CNT_W'(set_hit[i] & ~busy[i]);
      dec = dec + CNT_W'(clr_eff[i]);
    end
    cnt_nxt  = pend_count + inc - dec;
    busy_nxt = set_hit | (busy & ~clr_hit);
    busy_nxt[0] = 1'b0;
    if (flush) begin
      busy_nxt = '0;
      cnt_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy       <= '0;
      pend_count <= '0;
    end else begin
      busy       <= busy_nxt;
      pend_count <= cnt_nxt;
    end
  end

  always_comb begin
    wb_hit1 = 1'b0;
    wb_hit2 = 1'b0;
    for (int w = 0; w < IPRF_NUM_WRITES; w++) begin
      if (iprf_wr_en_ro0[w] && (int'(iprf_wr_pkt_ro0[w].pdst) == int'(rd_psrc1)))
        wb_hit1 = 1'b1;
      if (iprf_wr_en_ro0[w] && (int'(iprf_wr_pkt_ro0[w].pdst) == int'(rd_psrc2)))
        wb_hit2 = 1'b1;
    end
  end

`ifdef IPRF_BUSY_BYPASS_EN
  assign rd_psrc1_pend = busy[rd_psrc1] & ~wb_hit1;
  assign rd_psrc2_pend = busy[rd_psrc2] & ~wb_hit2;
`else
  logic unused_wb_hit;
  assign unused_wb_hit = wb_hit1 ^ wb_hit2;
  assign rd_psrc1_pend = busy[rd_psrc1];
  assign rd_psrc2_pend = busy[rd_psrc2];
`endif

endmodule
